// File: rtl/conv_sequencer.sv
// Frame-level sequencer for the convolver: loads kernel weights, streams pixels,
// tracks window position and overlaps the next kernel preload with streaming.
module conv_sequencer #(
  parameter int KSIZE = 3,
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  localparam int NW  = KSIZE * KSIZE,
  localparam int WIW = (NW > 1) ? $clog2(NW) : 1,
  localparam int CW  = (IMG_W > 1) ? $clog2(IMG_W) : 1,
  localparam int RW  = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           reload_req,
  input  logic           w_valid,
  output logic           w_ready,
  input  logic           px_valid,
  output logic           px_ready,
  output logic [1:0]     state,
  output logic [WIW-1:0] w_index,
  output logic [CW-1:0]  col,
  output logic [RW-1:0]  row,
  output logic           win_valid,
  output logic           done,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    WLOAD        = 2'b01,
    STREAM       = 2'b10,
    STREAM_WLOAD = 2'b11
  } state_t;

  localparam logic [WIW-1:0] W_LAST   = WIW'(NW - 1);
  localparam logic [CW-1:0]  COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0]  ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0]  WIN_COL  = CW'(KSIZE - 1);
  localparam logic [RW-1:0]  WIN_ROW  = RW'(KSIZE - 1);

  state_t         state_q, state_d;
  logic [WIW-1:0] w_index_d;
  logic [CW-1:0]  col_d;
  logic [RW-1:0]  row_d;
  logic           preload_done, preload_done_d;
  logic           w_acc, px_acc, w_last, frame_end;

  assign state    = state_q;
  assign w_ready  = state_q[0];
  assign px_ready = state_q[1];
  assign busy     = (state_q != IDLE);

  assign w_acc     = w_valid && w_ready;
  assign px_acc    = px_valid && px_ready;
  assign w_last    = w_acc && (w_index == W_LAST);
  assign frame_end = px_acc && (row == ROW_LAST) && (col == COL_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      w_index      <= '0;
      col          <= '0;
      row          <= '0;
      win_valid    <= 1'b0;
      done         <= 1'b0;
      preload_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_index      <= w_index_d;
      col          <= col_d;
      row          <= row_d;
      win_valid    <= px_acc && (row >= WIN_ROW) && (col >= WIN_COL);
      done         <= frame_end;
      preload_done <= preload_done_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    w_index_d      = w_index;
    col_d          = col;
    row_d          = row;
    preload_done_d = preload_done;

    if (w_acc) begin
      w_index_d = w_last ? '0 : w_index + 1'b1;
    end

    if (px_acc) begin
      if (col == COL_LAST) begin
        col_d = '0;
        row_d = (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col_d = col + 1'b1;
      end
    end

    // A weight completing in the frame-end cycle counts as a finished preload,
    // while a partial preload drops back to WLOAD keeping its w_index.
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = WLOAD;
          w_index_d = '0;
          col_d     = '0;
          row_d     = '0;
        end
      end
      WLOAD: begin
        if (w_last) state_d = STREAM;
      end
      STREAM: begin
        if (frame_end) begin
          state_d        = preload_done ? STREAM : IDLE;
          preload_done_d = 1'b0;
        end else if (reload_req && !preload_done) begin
          state_d = STREAM_WLOAD;
        end
      end
      STREAM_WLOAD: begin
        if (frame_end) begin
          state_d        = (preload_done || w_last) ? STREAM : WLOAD;
          preload_done_d = 1'b0;
        end else if (w_last) begin
          state_d        = STREAM;
          preload_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_conv_sequencer.sv
// Directed self-checking bench for conv_sequencer: weight loading, streaming,
// random handshake gaps, mid-frame reset and kernel preload overlap cases.
module tb_conv_sequencer;

  localparam int KSIZE = 3;
  localparam int IMG_W = 8;
  localparam int IMG_H = 8;
  localparam int NW    = KSIZE * KSIZE;
  localparam int NPIX  = IMG_W * IMG_H;
  localparam int NWIN  = (IMG_W - KSIZE + 1) * (IMG_H - KSIZE + 1);

  logic       clk = 1'b0;
  logic       reset, start, reload_req, w_valid, px_valid;
  logic       w_ready, px_ready, win_valid, done, busy;
  logic [1:0] state;
  logic [3:0] w_index;
  logic [2:0] col, row;

  int checks = 0;
  int errors = 0;

  conv_sequencer #(.KSIZE(KSIZE), .IMG_W(IMG_W), .IMG_H(IMG_H)) dut (
    .clk(clk), .reset(reset), .start(start), .reload_req(reload_req),
    .w_valid(w_valid), .w_ready(w_ready), .px_valid(px_valid), .px_ready(px_ready),
    .state(state), .w_index(w_index), .col(col), .row(row),
    .win_valid(win_valid), .done(done), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic win_at(input int p);
    return ((p / IMG_W) >= KSIZE - 1) && ((p % IMG_W) >= KSIZE - 1);
  endfunction

  task automatic apply_stimulus(input logic s, input logic rl, input logic wv, input logic pv);
    start      = s;
    reload_req = rl;
    w_valid    = wv;
    px_valid   = pv;
  endtask

  task automatic load_weights(input int first);
    for (int i = first; i < NW; i++) begin
      check("wload_state", state, 2'b01);
      check("wload_index", w_index, i);
      check("wload_ready", {w_ready, px_ready}, 2'b10);
      apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check("wload_to_stream", state, 2'b10);
    check("wload_wrap", w_index, 0);
  endtask

  // Streams one full frame at full pixel rate. When reload_at >= 0, reload_req
  // is raised with that pixel and weights are offered from the next pixel up
  // to w_end; STREAM_WLOAD is expected up to pixel st3_end.
  task automatic stream_frame(input int reload_at, input int w_end, input int st3_end,
                              input logic [1:0] end_state, input int end_w);
    int   wins  = 0;
    int   exp_w = 0;
    logic in_st3, wv;
    for (int k = 0; k < NPIX; k++) begin
      in_st3 = (reload_at >= 0) && (k > reload_at) && (k <= st3_end);
      wv     = (reload_at >= 0) && (k > reload_at) && (k <= w_end);
      check("px_row", row, k / IMG_W);
      check("px_col", col, k % IMG_W);
      check("px_state", state, in_st3 ? 2'b11 : 2'b10);
      check("px_w_index", w_index, exp_w);
      if (k > 0) begin
        check("px_win", win_valid, win_at(k - 1));
        check("px_done", done, 1'b0);
        if (win_valid) wins++;
      end
      apply_stimulus(1'b0, k == reload_at, wv, 1'b1);
      tick();
      if (wv) exp_w = (exp_w == NW - 1) ? 0 : exp_w + 1;
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    if (win_valid) wins++;
    check("end_done", done, 1'b1);
    check("end_win", win_valid, 1'b1);
    check("end_rowcol", {row, col}, 6'd0);
    check("end_state", state, end_state);
    check("end_w_index", w_index, end_w);
    check("end_win_count", wins, NWIN);
  endtask

  initial begin
    int exp_w, accepted, cyc, exp_pix, wins;
    logic exp_win;

    reset = 1'b1;
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("rst_state", state, 2'b00);
    check("rst_outputs", {w_index, row, col, win_valid, done, busy}, 0);
    reset = 1'b0;
    tick();
    check("idle_hold", state, 2'b00);

    $display("[TB] full-rate frame");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    load_weights(0);
    stream_frame(-1, -1, -1, 2'b00, 0);
    tick();
    check("post_done_clear", {done, win_valid, busy}, 3'b000);

    $display("[TB] random handshake gaps");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    exp_w = 0; accepted = 0; cyc = 0;
    while (accepted < NW && cyc < 500) begin
      check("rnd_w_state", state, 2'b01);
      check("rnd_w_index", w_index, exp_w);
      check("rnd_w_rowcol", {row, col}, 6'd0);
      apply_stimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
      cyc++;
      if (w_valid) begin
        accepted++;
        exp_w = (exp_w == NW - 1) ? 0 : exp_w + 1;
      end
    end
    check("rnd_w_timeout", accepted, NW);
    check("rnd_w_to_stream", state, 2'b10);
    exp_pix = 0; wins = 0; cyc = 0; exp_win = 1'b0;
    while (exp_pix < NPIX && cyc < 1000) begin
      check("rnd_px_row", row, exp_pix / IMG_W);
      check("rnd_px_col", col, exp_pix % IMG_W);
      check("rnd_px_w_index", w_index, 0);
      check("rnd_px_win", win_valid, exp_win);
      apply_stimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
      cyc++;
      if (win_valid) wins++;
      if (px_valid) begin
        exp_win = win_at(exp_pix);
        exp_pix++;
      end else begin
        exp_win = 1'b0;
      end
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check("rnd_px_timeout", exp_pix, NPIX);
    check("rnd_done", done, 1'b1);
    check("rnd_win_count", wins, NWIN);
    check("rnd_idle", state, 2'b00);
    tick();

    $display("[TB] reset mid-frame");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    load_weights(0);
    for (int k = 0; k < 3 * IMG_W + 5; k++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    check("mid_rowcol", {row, col}, {3'd3, 3'd5});
    check("mid_win", win_valid, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_state", state, 2'b00);
    check("midrst_outputs", {w_index, row, col, win_valid, done, busy}, 0);

    $display("[TB] early preload, back-to-back frames");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    load_weights(0);
    stream_frame(10, 19, 19, 2'b10, 0);
    stream_frame(-1, -1, -1, 2'b00, 0);
    tick();

    $display("[TB] partial preload, then simultaneous finish");
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
    load_weights(0);
    stream_frame(60, 62, 63, 2'b01, 2);
    load_weights(2);
    stream_frame(54, 63, 63, 2'b10, 0);
    stream_frame(-1, -1, -1, 2'b00, 0);
    tick();
    check("final_idle", {state, done, busy}, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
